// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator core and its divider.
package calc_pkg;

  // State codes double as the phase LED pattern.
  typedef enum logic [1:0] {
    ST_ENTER_A = 2'b00,
    ST_ENTER_B = 2'b01,
    ST_CALC    = 2'b10,
    ST_SHOW    = 2'b11
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  // Restoring division retires one quotient bit per cycle.
  localparam int DIV_ITERS = 8;

endpackage

// File: rtl/calc_sdiv8.sv
// Sequential signed 8-bit divider, truncating toward zero.
// Start cycle captures magnitudes and special cases; then DIV_ITERS
// restoring shift-subtract steps. done pulses during the last step with
// the signed quotient presented combinationally alongside it.
module sdiv8
  import calc_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic       done,
  output logic [7:0] quotient,
  output logic       dz,
  output logic       ovf
);

  localparam logic [2:0] LAST_ITER = 3'(DIV_ITERS - 1);

  logic       running;
  logic [2:0] cnt;
  logic [7:0] work;     // dividend bits shift out the top, quotient bits in the bottom
  logic [7:0] rem;
  logic [7:0] dvs;
  logic       neg;
  logic       dz_r;
  logic       ovf_r;

  logic [8:0] rem_sh;
  logic [9:0] trial;
  logic       fits;
  logic [7:0] rem_next;
  logic [7:0] work_next;

  function automatic logic [7:0] mag8(input logic [7:0] x);
    // -128 maps to 8'h80, which is 128 when read as unsigned.
    return x[7] ? 8'(-x) : x;
  endfunction

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    rem_sh    = {rem, work[7]};
    trial     = {1'b0, rem_sh} - {2'b00, dvs};
    fits      = ~trial[9];
    rem_next  = fits ? trial[7:0] : rem_sh[7:0];
    work_next = {work[6:0], fits};
  end

  assign done = running && (cnt == LAST_ITER);
  assign dz   = dz_r;
  assign ovf  = ovf_r;

  // Sign application and special-case override of the final quotient.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    quotient = neg ? 8'(-work_next) : work_next;
    if (dz_r)
      quotient = 8'h00;
    else if (ovf_r)
      quotient = 8'h80;
  end

  // Iteration control and datapath registers; abort wins over start.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples the pre-edge values regardless of statement order.
      running <= 1'b0;
      cnt     <= '0;
      work    <= '0;
      rem     <= '0;
      dvs     <= '0;
      neg     <= 1'b0;
      dz_r    <= 1'b0;
      ovf_r   <= 1'b0;
    end else if (abort) begin
      running <= 1'b0;
      cnt     <= '0;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= '0;
      work    <= mag8(a);
      rem     <= '0;
      dvs     <= mag8(b);
      neg     <= a[7] ^ b[7];
      dz_r    <= (b == 8'h00);
      ovf_r   <= (a == 8'h80) && (b == 8'hFF);
    end else if (running) begin
      rem  <= rem_next;
      work <= work_next;
      cnt  <= cnt + 3'd1;
      if (done)
        running <= 1'b0;
    end
  end

endmodule

// File: rtl/calc_core.sv
// Sequential arithmetic core of the push-button calculator: collects two
// signed operands and an operation, computes, and holds the result with
// sticky overflow / divide-by-zero flags until the next entry.
module calc_core
  import calc_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] sw,
  input  logic [1:0] op,
  input  logic       enter_pulse,
  input  logic       clear_pulse,
  output logic [7:0] value,
  output logic       ovf,
  output logic       dz,
  output logic       busy,
  output logic [1:0] phase
);

  state_t      state;
  logic [7:0]  a_reg;
  logic [7:0]  b_reg;
  logic [1:0]  opcode;
  logic [7:0]  result;
  logic        div_start;

  logic [7:0]         sum;
  logic [7:0]         diff;
  logic signed [15:0] prod;
  logic [7:0]         alu_val;
  logic               alu_ovf;

  logic       div_done;
  logic [7:0] div_q;
  logic       div_dz;
  logic       div_ovf;

  sdiv8 u_div (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (div_start),
    .abort    (clear_pulse),
    .a        (a_reg),
    .b        (b_reg),
    .done     (div_done),
    .quotient (div_q),
    .dz       (div_dz),
    .ovf      (div_ovf)
  );

  assign sum  = a_reg + b_reg;
  assign diff = a_reg - b_reg;
  assign prod = $signed(a_reg) * $signed(b_reg);

  // Single-cycle add/sub/mul result and overflow.
  always_comb begin
    alu_val = sum;
    alu_ovf = (a_reg[7] == b_reg[7]) && (sum[7] != a_reg[7]);
    case (opcode)
      OP_SUB: begin
        alu_val = diff;
        alu_ovf = (a_reg[7] != b_reg[7]) && (diff[7] != a_reg[7]);
      end
      OP_MUL: begin
        alu_val = prod[7:0];
        alu_ovf = (prod[15:8] != {8{prod[7]}});
      end
      default: ;
    endcase
  end

  // Display value: switch echo while entering, B during compute, else result.
  always_comb begin
    value = sw;
    case (state)
      ST_CALC: value = b_reg;
      ST_SHOW: value = result;
      default: ;
    endcase
  end

  assign phase = state;
  assign busy  = (state == ST_CALC);

  // Main FSM with operand, result and flag registers; clear beats enter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_ENTER_A;
      a_reg     <= '0;
      b_reg     <= '0;
      opcode    <= OP_ADD;
      result    <= '0;
      ovf       <= 1'b0;
      dz        <= 1'b0;
      div_start <= 1'b0;
    end else if (clear_pulse) begin
      state     <= ST_ENTER_A;
      a_reg     <= '0;
      b_reg     <= '0;
      result    <= '0;
      ovf       <= 1'b0;
      dz        <= 1'b0;
      div_start <= 1'b0;
    end else begin
      div_start <= 1'b0;
      case (state)
        ST_ENTER_A: begin
          if (enter_pulse) begin
            a_reg <= sw;
            state <= ST_ENTER_B;
          end
        end
        ST_ENTER_B: begin
          if (enter_pulse) begin
            b_reg     <= sw;
            opcode    <= op;
            div_start <= (op == OP_DIV);
            state     <= ST_CALC;
          end
        end
        ST_CALC: begin
          if (opcode == OP_DIV) begin
            if (div_done) begin
              result <= div_q;
              ovf    <= div_ovf;
              dz     <= div_dz;
              state  <= ST_SHOW;
            end
          end else begin
            result <= alu_val;
            ovf    <= alu_ovf;
            dz     <= 1'b0;
            state  <= ST_SHOW;
          end
        end
        ST_SHOW: begin
          if (enter_pulse) begin
            a_reg <= result;
            ovf   <= 1'b0;
            dz    <= 1'b0;
            state <= ST_ENTER_B;
          end
        end
        default: state <= ST_ENTER_A;
      endcase
    end
  end

endmodule
